seq_loader: RTL and testbench
=============================

# seq_loader

Upstream feeder for `smith_waterman`. It accepts an ASCII nucleotide character stream over a valid/ready handshake and encodes each base into the 2-bit code used by the aligner. It packs the first `REF_LEN` bases into `ref_seq` and the next `QUERY_LEN` bases into `query_seq`, then presents the pair to the aligner and holds it until acknowledged. Framing and character errors are flagged, and the offending input is discarded, so the aligner only ever sees complete, well-formed pairs.

## Interface
- `REF_LEN`, 15: reference length in bases.
- `QUERY_LEN`, 10: query length in bases.
- `BASE_WIDTH`, 2: bits per encoded base. Fixed at 2; other values are unsupported.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_char` and `in_last` are valid.
- `in_ready`  out  1  loader can accept a character.
- `in_char`  in  8  ASCII character.
- `in_last`  in  1  marks the final base of the current sequence (reference or query).
- `ref_seq`  out  `REF_LEN*BASE_WIDTH`  packed reference; first base received is in the MSBs.
- `query_seq`  out  `QUERY_LEN*BASE_WIDTH`  packed query; first base received is in the MSBs.
- `seq_valid`  out  1  pair complete and stable.
- `seq_ack`  in  1  aligner has taken the pair.
- `err_char`  out  1  one-cycle pulse: illegal character dropped.
- `err_len`  out  1  one-cycle pulse: length/framing error, pair discarded.
- `pair_count`  out  8  number of pairs delivered; wraps 255 -> 0.

## Operation
- Encoding: `A/a`=00, `T/t`=01, `G/g`=10, `C/c`=11.
  - Any other character is consumed, not counted and not stored; `err_char` pulses.
- Storage: each accepted base shifts into the LSBs, e.g. `ref_seq <= {ref_seq[W-3:0], code}`. After LEN shifts, base 0 sits at `[W-1:W-2]`.
- A transfer occurs when `in_valid && in_ready` at a clock edge.
- FSM states: `S_REF`, `S_QRY`, `S_FLUSH`, `S_DONE`.
  - `S_REF`:
    - A legal base increments `cnt`.
    - Base number `REF_LEN` (`cnt == REF_LEN-1`) with `in_last=1`: go to `S_QRY`, `cnt` <= 0.
    - Same base with `in_last=0`: `err_len`, go to `S_FLUSH`.
    - Legal base with `in_last=1` and `cnt < REF_LEN-1`: `err_len`, `cnt` <= 0, stay in `S_REF` (pair discarded).
  - `S_QRY`: same rules against `QUERY_LEN`.
    - A correct terminating base goes to `S_DONE`.
    - An early `in_last` returns to `S_REF` with `err_len`, and the reference is discarded.
  - `S_FLUSH`: consume characters until a transfer with `in_last=1`, then go to `S_REF`, `cnt` <= 0. No error pulses in this state.
  - `S_DONE`: `seq_valid=1`, `in_ready=0`. On `seq_ack`: go to `S_REF`, `cnt` <= 0, `pair_count` increments.
- `in_last` on an illegal character: `err_char` and `err_len` both pulse, the pair is discarded, and the FSM returns to `S_REF`.
- `ref_seq` and `query_seq` are guaranteed stable only while `seq_valid=1`. They change as the next pair loads.

## Timing
- Reset values (asynchronous, immediate on `rst` high):
  - `S_REF`, `cnt`=0, `ref_seq`=0, `query_seq`=0.
  - `seq_valid`=0, `err_char`=0, `err_len`=0, `pair_count`=0.
  - `in_ready`=0 while `rst` is high, and 1 from the first cycle after release.
- `in_ready` is a combinational decode of state: 1 in `S_REF`, `S_QRY` and `S_FLUSH`; 0 in `S_DONE`. It has no dependency on `in_valid`.
- Throughput: one character per cycle.
- Latency: the last query base is accepted at edge N; `seq_valid`=1 from edge N (visible cycle N+1). Best case from the first base is `REF_LEN+QUERY_LEN` cycles.
- `seq_ack` when `seq_valid`=1 is sampled at edge M. `seq_valid`=0 and `in_ready`=1 from edge M, so a new character can be accepted at edge M+1. `seq_ack` while `seq_valid`=0 is ignored.
- Error pulses are registered and last exactly one cycle, asserted after the offending transfer edge.
- Reset mid-load discards everything. No partial pair is ever presented.

## Test plan
- Reset, then stream `GTATGCATTGCATGG` (`in_last` on the final G) followed by `ATGCATTGCA` (`in_last` on the final A), one character per cycle -> `seq_valid` 25 cycles after the first transfer, `ref_seq`=30'h246C5B1A, `query_seq`=20'h1B16C.
- Hold `seq_ack`=0 for 10 cycles, then pulse it -> `in_ready`=0 and outputs stable throughout; `seq_valid` drops and `pair_count`=1 after the ack edge.
- Insert `N` and `x` inside the reference stream -> two `err_char` pulses; the packed result is identical to the clean case.
- `in_last` on the 12th reference base -> `err_len` pulse, FSM in `S_REF` with `cnt`=0. A following clean pair loads correctly.
- 16 query characters with `in_last` only on the 16th -> `err_len` at the 10th base, 6 characters flushed, no `seq_valid`. The next pair succeeds.
- Assert `rst` after 20 bases -> immediate return to reset values. The next full pair gives `pair_count`=1 after ack.

Source files
------------

// File: rtl/seq_loader_if.sv
// Stream and pair-delivery signals between the character feeder, seq_loader and the aligner.
// The master side drives characters and acks; the slave side is the loader.
interface seq_loader_if #(
    parameter int unsigned REF_LEN    = 15,
    parameter int unsigned QUERY_LEN  = 10,
    parameter int unsigned BASE_WIDTH = 2
);
    logic                              in_valid;
    logic                              in_ready;
    logic [7:0]                        in_char;
    logic                              in_last;
    logic [REF_LEN*BASE_WIDTH-1:0]     ref_seq;
    logic [QUERY_LEN*BASE_WIDTH-1:0]   query_seq;
    logic                              seq_valid;
    logic                              seq_ack;
    logic                              err_char;
    logic                              err_len;
    logic [7:0]                        pair_count;

    modport master (
        output in_valid, in_char, in_last, seq_ack,
        input  in_ready, ref_seq, query_seq, seq_valid, err_char, err_len, pair_count
    );

    modport slave (
        input  in_valid, in_char, in_last, seq_ack,
        output in_ready, ref_seq, query_seq, seq_valid, err_char, err_len, pair_count
    );
endinterface

// File: rtl/seq_loader.sv
// Encodes an ASCII nucleotide stream into 2-bit bases and packs a reference/query pair
// for the aligner, discarding malformed frames and flagging character/length errors.
module seq_loader #(
    parameter int unsigned REF_LEN    = 15,
    parameter int unsigned QUERY_LEN  = 10,
    parameter int unsigned BASE_WIDTH = 2
) (
    input logic          clk,
    input logic          rst,
    seq_loader_if.slave  bus
);
    localparam int unsigned RefW   = REF_LEN * BASE_WIDTH;
    localparam int unsigned QryW   = QUERY_LEN * BASE_WIDTH;
    localparam int unsigned MaxLen = (REF_LEN > QUERY_LEN) ? REF_LEN : QUERY_LEN;
    localparam int unsigned CntW   = $clog2(MaxLen);

    typedef enum logic [1:0] {S_REF, S_QRY, S_FLUSH, S_DONE} state_t;

    state_t                 state;
    logic [CntW-1:0]        cnt;
    logic [RefW-1:0]        ref_seq;
    logic [QryW-1:0]        query_seq;
    logic                   seq_valid;
    logic                   err_char;
    logic                   err_len;
    logic [7:0]             pair_count;

    logic                   legal;
    logic [BASE_WIDTH-1:0]  code;
    logic                   xfer;
    logic                   at_end;

    always_comb begin
        legal = 1'b1;
        code  = '0;
        case (bus.in_char)
            "A", "a": code = BASE_WIDTH'(0);
            "T", "t": code = BASE_WIDTH'(1);
            "G", "g": code = BASE_WIDTH'(2);
            "C", "c": code = BASE_WIDTH'(3);
            default:  legal = 1'b0;
        endcase
    end

    assign xfer   = bus.in_valid && bus.in_ready;
    assign at_end = (state == S_REF) ? (cnt == CntW'(REF_LEN - 1))
                                     : (cnt == CntW'(QUERY_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REF;
            cnt        <= '0;
            ref_seq    <= '0;
            query_seq  <= '0;
            seq_valid  <= 1'b0;
            err_char   <= 1'b0;
            err_len    <= 1'b0;
            pair_count <= '0;
        end else begin
            err_char <= 1'b0;
            err_len  <= 1'b0;
            case (state)
                S_REF, S_QRY: begin
                    if (xfer) begin
                        if (!legal) begin
                            err_char <= 1'b1;
                            // A framing marker on a bad character still ends the frame.
                            if (bus.in_last) begin
                                err_len <= 1'b1;
                                cnt     <= '0;
                                state   <= S_REF;
                            end
                        end else begin
                            if (state == S_REF) begin
                                ref_seq <= {ref_seq[RefW-BASE_WIDTH-1:0], code};
                            end else begin
                                query_seq <= {query_seq[QryW-BASE_WIDTH-1:0], code};
                            end
                            if (at_end) begin
                                cnt <= '0;
                                if (!bus.in_last) begin
                                    err_len <= 1'b1;
                                    state   <= S_FLUSH;
                                end else if (state == S_REF) begin
                                    state <= S_QRY;
                                end else begin
                                    state     <= S_DONE;
                                    seq_valid <= 1'b1;
                                end
                            end else if (bus.in_last) begin
                                err_len <= 1'b1;
                                cnt     <= '0;
                                state   <= S_REF;
                            end else begin
                                cnt <= cnt + CntW'(1);
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (xfer && bus.in_last) begin
                        state <= S_REF;
                        cnt   <= '0;
                    end
                end
                S_DONE: begin
                    if (bus.seq_ack) begin
                        state      <= S_REF;
                        cnt        <= '0;
                        seq_valid  <= 1'b0;
                        pair_count <= pair_count + 8'd1;
                    end
                end
                default: state <= S_REF;
            endcase
        end
    end

    assign bus.in_ready   = !rst && (state != S_DONE);
    assign bus.ref_seq    = ref_seq;
    assign bus.query_seq  = query_seq;
    assign bus.seq_valid  = seq_valid;
    assign bus.err_char   = err_char;
    assign bus.err_len    = err_len;
    assign bus.pair_count = pair_count;
endmodule

// File: tb/tb_seq_loader.sv
// Directed bench for seq_loader: clean pairs, ack handshake, character and framing errors,
// flush of an overlong query and asynchronous reset mid-load.
module tb_seq_loader;
    localparam int unsigned REF_LEN    = 15;
    localparam int unsigned QUERY_LEN  = 10;
    localparam int unsigned BASE_WIDTH = 2;
    localparam logic [31:0] ExpRef     = 32'h246C5B1A;
    localparam logic [31:0] ExpQry     = 32'h0001B16C;

    logic clk;
    logic rst;
    int   total;
    int   fails;
    int   n_char;
    int   n_len;

    seq_loader_if #(.REF_LEN(REF_LEN), .QUERY_LEN(QUERY_LEN), .BASE_WIDTH(BASE_WIDTH)) bus ();

    seq_loader #(.REF_LEN(REF_LEN), .QUERY_LEN(QUERY_LEN), .BASE_WIDTH(BASE_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and tally any error pulse visible after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.err_char === 1'b1) n_char++;
        if (bus.err_len === 1'b1) n_len++;
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_end);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], last_end && (i == s.len() - 1));
        end
    endtask

    task automatic load_pair();
        send_str("GTATGCATTGCATGG", 1'b1);
        send_str("ATGCATTGCA", 1'b1);
    endtask

    task automatic ack();
        bus.seq_ack = 1'b1;
        tick();
        bus.seq_ack = 1'b0;
    endtask

    task automatic chk_pair(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.seq_valid}, 32'd1);
        chk({tag, "_ref"}, {2'd0, bus.ref_seq}, ExpRef);
        chk({tag, "_qry"}, {12'd0, bus.query_seq}, ExpQry);
    endtask

    initial begin
        total = 0; fails = 0; n_char = 0; n_len = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_char = 8'h00; bus.in_last = 1'b0; bus.seq_ack = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_valid", {31'd0, bus.seq_valid}, 32'd0);
        chk("rst_ref", {2'd0, bus.ref_seq}, 32'd0);
        chk("rst_qry", {12'd0, bus.query_seq}, 32'd0);
        chk("rst_cnt", {24'd0, bus.pair_count}, 32'd0);
        chk("rst_err", {30'd0, bus.err_char, bus.err_len}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

        // Clean pair: seq_valid only after the 25th transfer
        send_str("GTATGCATTGCATGG", 1'b1);
        chk("ref_done_no_valid", {31'd0, bus.seq_valid}, 32'd0);
        send_str("ATGCATTGC", 1'b0);
        chk("base24_no_valid", {31'd0, bus.seq_valid}, 32'd0);
        send("A", 1'b1);
        chk_pair("clean");
        chk("clean_not_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("clean_errs", n_char + n_len, 32'd0);

        // Hold ack low: outputs frozen, loader not ready
        for (int i = 0; i < 10; i++) begin
            send("C", 1'b1);
            chk("hold_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_ref", {2'd0, bus.ref_seq}, ExpRef);
            chk("hold_qry", {12'd0, bus.query_seq}, ExpQry);
            chk("hold_valid", {31'd0, bus.seq_valid}, 32'd1);
        end
        ack();
        chk("ack_valid", {31'd0, bus.seq_valid}, 32'd0);
        chk("ack_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("ack_count", {24'd0, bus.pair_count}, 32'd1);
        ack();
        chk("stray_ack_ignored", {24'd0, bus.pair_count}, 32'd1);

        // Illegal characters inside the reference are dropped
        n_char = 0; n_len = 0;
        send_str("GTATGNCATTxGCATGG", 1'b1);
        send_str("ATGCATTGCA", 1'b1);
        chk("bad_char_pulses", n_char, 32'd2);
        chk("bad_char_no_len", n_len, 32'd0);
        chk_pair("bad_char");
        ack();
        chk("bad_char_count", {24'd0, bus.pair_count}, 32'd2);

        // Early in_last on the 12th reference base
        n_char = 0; n_len = 0;
        send_str("GTATGCATTGCA", 1'b1);
        chk("short_ref_len", n_len, 32'd1);
        chk("short_ref_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("short_ref_cnt", {28'd0, dut.cnt}, 32'd0);
        load_pair();
        chk_pair("after_short");
        chk("after_short_len", n_len, 32'd1);
        ack();
        chk("after_short_count", {24'd0, bus.pair_count}, 32'd3);

        // 16-character query: error at the 10th, remaining 6 flushed silently
        n_char = 0; n_len = 0;
        send_str("GTATGCATTGCATGG", 1'b1);
        send_str("ATGCATTGCA", 1'b0);
        chk("long_qry_len_at10", n_len, 32'd1);
        send_str("TTTTTG", 1'b1);
        chk("flush_no_more_err", n_len + n_char, 32'd1);
        chk("flush_no_valid", {31'd0, bus.seq_valid}, 32'd0);
        load_pair();
        chk_pair("after_flush");
        ack();
        chk("after_flush_count", {24'd0, bus.pair_count}, 32'd4);

        // Early in_last in the query, then illegal character carrying in_last
        n_char = 0; n_len = 0;
        send_str("GTATGCATTGCATGG", 1'b1);
        send_str("ATGCA", 1'b1);
        chk("short_qry_len", n_len, 32'd1);
        send_str("GTATGCATTGCATGG", 1'b1);
        send_str("ATN", 1'b1);
        chk("bad_last_char", n_char, 32'd1);
        chk("bad_last_len", n_len, 32'd2);
        chk("bad_last_no_valid", {31'd0, bus.seq_valid}, 32'd0);
        load_pair();
        chk_pair("after_bad_last");
        ack();
        chk("after_bad_last_count", {24'd0, bus.pair_count}, 32'd5);

        // Asynchronous reset after 20 bases
        send_str("GTATGCATTGCATGG", 1'b1);
        send_str("ATGCA", 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("mid_rst_ref", {2'd0, bus.ref_seq}, 32'd0);
        chk("mid_rst_qry", {12'd0, bus.query_seq}, 32'd0);
        chk("mid_rst_count", {24'd0, bus.pair_count}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        load_pair();
        chk_pair("post_rst");
        ack();
        chk("post_rst_count", {24'd0, bus.pair_count}, 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
